// File: rtl/commit_order_checker.sv
// Retirement-order checker: observes the ROB commit lanes, flags tag-order,
// lane-hole and bad-free violations, and reports pass/fail/timeout status.
module commit_order_checker #(
    parameter int COMMIT_WIDTH = 1,
    parameter int TAG_W        = 4,
    parameter int PREG_W       = 6,
    parameter int EXPECT_N     = 7,
    parameter int TIMEOUT      = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COMMIT_WIDTH-1:0]        commit_valid,
    input  logic [COMMIT_WIDTH*TAG_W-1:0]  commit_tag,
    input  logic [COMMIT_WIDTH*PREG_W-1:0] commit_old_preg,
    input  logic [COMMIT_WIDTH-1:0]        commit_regwrite,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           err_order,
    output logic                           err_free,
    output logic                           err_timeout,
    output logic [TAG_W-1:0]               first_err_tag,
    output logic [15:0]                    commit_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int K_W  = $clog2(COMMIT_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  exp_tag_q, exp_tag_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_order_q, err_order_d;
    logic              err_free_q, err_free_d;
    logic              err_timeout_q, err_timeout_d;
    logic [TAG_W-1:0]  fet_q, fet_d;
    logic              busy_q, done_q, pass_q;

    logic [K_W-1:0]    k;
    logic              seen_gap;
    logic              order_bad;
    logic              free_bad;
    logic              off_found;
    logic [TAG_W-1:0]  off_tag;
    logic [TAG_W-1:0]  lane_tag;
    logic              lane_order_bad;
    logic              lane_free_bad;
    logic [16:0]       sum;
    logic              to_hit;
    logic              any_err;

    // Per-lane analysis: count valid lanes and locate the lowest offending lane.
    always_comb begin
        k         = '0;
        seen_gap  = 1'b0;
        order_bad = 1'b0;
        free_bad  = 1'b0;
        off_found = 1'b0;
        off_tag   = '0;
        lane_tag  = '0;
        lane_order_bad = 1'b0;
        lane_free_bad  = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_tag       = commit_tag[i*TAG_W +: TAG_W];
            lane_order_bad = 1'b0;
            lane_free_bad  = 1'b0;
            if (commit_valid[i]) begin
                k              = k + K_W'(1);
                lane_order_bad = seen_gap || (lane_tag != exp_tag_q + TAG_W'(i));
                lane_free_bad  = !commit_regwrite[i] &&
                                 (commit_old_preg[i*PREG_W +: PREG_W] != '0);
                if ((lane_order_bad || lane_free_bad) && !off_found) begin
                    off_found = 1'b1;
                    off_tag   = lane_tag;
                end
            end else begin
                seen_gap = 1'b1;
            end
            order_bad = order_bad | lane_order_bad;
            free_bad  = free_bad | lane_free_bad;
        end
    end

    always_comb begin
        state_d       = state_q;
        exp_tag_d     = exp_tag_q;
        wd_d          = wd_q;
        cnt_d         = cnt_q;
        err_order_d   = err_order_q;
        err_free_d    = err_free_q;
        err_timeout_d = err_timeout_q;
        fet_d         = fet_q;
        sum           = {1'b0, cnt_q} + 17'(k);
        to_hit        = (k == '0) && (wd_q == WD_W'(TIMEOUT - 1));
        any_err       = order_bad || free_bad || to_hit;
        case (state_q)
            S_RUN: begin
                exp_tag_d     = exp_tag_q + TAG_W'(k);
                cnt_d         = sum[16] ? 16'hFFFF : sum[15:0];
                wd_d          = (k != '0) ? '0 : wd_q + WD_W'(1);
                err_order_d   = err_order_q | order_bad;
                err_free_d    = err_free_q | free_bad;
                err_timeout_d = err_timeout_q | to_hit;
                // A timeout cycle has no valid lanes, so off_tag is 0 there.
                if (any_err && !(err_order_q || err_free_q || err_timeout_q))
                    fet_d = off_found ? off_tag : '0;
                if (any_err)
                    state_d = S_FAIL;
                else if (sum >= 17'(EXPECT_N))
                    state_d = S_PASS;
            end
            default: begin
                if (start) begin
                    state_d       = S_RUN;
                    exp_tag_d     = '0;
                    wd_d          = '0;
                    cnt_d         = '0;
                    err_order_d   = 1'b0;
                    err_free_d    = 1'b0;
                    err_timeout_d = 1'b0;
                    fet_d         = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            exp_tag_q     <= '0;
            wd_q          <= '0;
            cnt_q         <= '0;
            err_order_q   <= 1'b0;
            err_free_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            fet_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_tag_q     <= exp_tag_d;
            wd_q          <= wd_d;
            cnt_q         <= cnt_d;
            err_order_q   <= err_order_d;
            err_free_q    <= err_free_d;
            err_timeout_q <= err_timeout_d;
            fet_q         <= fet_d;
            busy_q        <= (state_d == S_RUN);
            done_q        <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q        <= (state_d == S_PASS);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_order     = err_order_q;
    assign err_free      = err_free_q;
    assign err_timeout   = err_timeout_q;
    assign first_err_tag = fet_q;
    assign commit_count  = cnt_q;

endmodule

// File: doc/commit_order_checker.md
# commit_order_checker

Synthesizable retirement checker that watches the ROB commit interface and flags architectural-order violations on silicon or FPGA builds. It covers in-order tags, packed commit lanes, and stores or branches wrongly freeing a physical register. It also reports pass/fail/timeout status for a self-checking program of known length. It sits beside the ROB in OoO_top and observes the commit interface without driving it. It is parametrised for multi-wide retirement and any ROB depth.

## Interface
- COMMIT_WIDTH, 1, retire lanes per cycle (1..4)
- TAG_W, 4, ROB tag width; tags wrap modulo 2^TAG_W
- PREG_W, 6, physical register index width
- EXPECT_N, 7, committed-instruction count that constitutes a pass
- TIMEOUT, 1000, max cycles in RUN with no commit before failure (>=2)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; arms the checker from IDLE or DONE
- commit_valid  input  COMMIT_WIDTH  per-lane retire valid
- commit_tag  input  COMMIT_WIDTH*TAG_W  per-lane ROB tag, lane i at [i*TAG_W +: TAG_W]
- commit_old_preg  input  COMMIT_WIDTH*PREG_W  per-lane freed physical register
- commit_regwrite  input  COMMIT_WIDTH  per-lane "instruction writes rd"
- busy  output  1  state == RUN
- done  output  1  state == PASS or FAIL
- pass  output  1  state == PASS
- err_order  output  1  sticky: tag mismatch or lane hole
- err_free  output  1  sticky: non-writing instruction freed P!=0
- err_timeout  output  1  sticky: watchdog expired
- first_err_tag  output  TAG_W  tag of the lowest-numbered offending lane in the first error cycle
- commit_count  output  16  instructions accepted since start, saturating at 0xFFFF

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE → RUN on start. Clears the counts, errors, and watchdog. Expected tag exp_tag = 0.
- RUN, per cycle with k = popcount(commit_valid):
  - Lane hole: the valid lanes must form a contiguous prefix from lane 0. Any valid lane above an invalid one sets err_order.
  - Tag check: valid lane i must carry (exp_tag + i) mod 2^TAG_W. A mismatch sets err_order.
  - Free check: valid lane with regwrite=0 and old_preg≠0 sets err_free. The regwrite=1 case is unchecked.
  - exp_tag advances by k modulo 2^TAG_W, even when errors occur. commit_count advances by k, saturating.
  - Watchdog: cleared when k>0, otherwise incremented. Reaching TIMEOUT sets err_timeout.
- RUN → FAIL when any error flag is set this cycle.
- RUN → PASS when commit_count+k ≥ EXPECT_N and no error occurs this cycle. If both apply in the same cycle, FAIL wins.
- first_err_tag is captured only on the cycle the first error is recorded. For a timeout with no prior error it holds 0.
- PASS/FAIL: all outputs frozen. Commit inputs are ignored. start re-arms into RUN with everything cleared.
- IDLE: commit inputs are ignored. start while already in RUN is ignored.

## Timing
- All outputs are registered. Flags and state reflect a commit sampled at edge n from edge n onward, so they are visible in cycle n+1.
- Reset values: state IDLE, so busy=0, done=0, pass=0. err_*=0, first_err_tag=0, commit_count=0. Internally, exp_tag=0 and watchdog=0.
- Reset mid-RUN returns to IDLE on the same edge. start is ignored when sampled together with rst.
- Tag wrap: with TAG_W=4, exp_tag=15 and two lanes valid, the expected tags are 15 and 0, and the next exp_tag is 1.
- Watchdog: with a last commit at edge n and no further commits, err_timeout sets at edge n+TIMEOUT.
- A start pulse at edge s makes the first commit counted the one sampled at edge s+1.

## Test plan
- Sequence, COMMIT_WIDTH=1, EXPECT_N=7: start, then commit tags 0..6 one per cycle. The SW at tag 3 and the BEQ at tag 5 have regwrite=0 and old_preg=0. Required: pass=1 one cycle after the tag-6 edge, commit_count=7, all errors 0.
- Bad free: same sequence but tag 3 carries regwrite=0 and old_preg=5. Required: err_free=1, first_err_tag=3, state FAIL, and commit_count frozen at 4.
- Wrap, COMMIT_WIDTH=2, TAG_W=4, EXPECT_N=20: commit pairs (0,1)…(14,15), then (0,1), (2,3). Required: pass with no err_order. A variant sending (0,2) at the wrap point requires err_order and first_err_tag=2.
- Lane hole, COMMIT_WIDTH=4: commit_valid=4'b0101 with tags 0 and 2. Required: err_order=1 and first_err_tag=2.
- Timeout, TIMEOUT=50: start, commit tags 0 and 1, then idle. Required: err_timeout=1 exactly 50 edges after the tag-1 edge, with first_err_tag=0 and FAIL.
- Simultaneous events plus reset:
  - EXPECT_N=2: tag 1 arrives with a bad free on the final commit. Required: FAIL, not PASS.
  - rst asserted mid-RUN: all outputs are at reset values on the next cycle.
  - start after a FAIL: re-arms to RUN with the flags clear.
